// File: rtl/z80_bus_responder.sv
// ============================================================================
// z80_bus_responder
// ----------------------------------------------------------------------------
// Memory/IO slave for a Z80-style CPU bus. It decodes memory and IO cycles and
// optionally stretches them with wait states. It serves reads from a 2^AW-byte
// RAM or a 16-byte IO register file. Every completed write is recorded in a
// small write-log FIFO that a consumer drains with a valid/ready handshake.
//
// Configuration macro:
//   Z80_RESP_WAIT_EN  When defined, each access spends WAIT_CYCLES cycles in a
//                     WAIT state with wait_n low. When undefined, the WAIT state
//                     and its counter do not exist, wait_n is tied high, and an
//                     access goes straight from IDLE to ACCESS.
//
// Parameters:
//   AW           RAM address width (RAM indexed by a[AW-1:0], upper bits alias)
//   WAIT_CYCLES  wait states per access, 0..7 (used only with Z80_RESP_WAIT_EN)
//   LOG_DEPTH    write-log depth, power of two, >= 2
//
// Ports:
//   clk        rising-edge clock shared with the CPU
//   reset_n    asynchronous active-low reset
//   a          CPU address bus
//   dout       CPU write data
//   di         read data to the CPU (8'hFF when not driving a read)
//   mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n   CPU strobes, active-low
//   wait_n     wait request to the CPU, active-low
//   log_valid  write-log holds at least one entry
//   log_data   {is_io, address[15:0], data[7:0]} of the oldest entry, 0 if empty
//   log_ready  pop the oldest entry when log_valid is also high
//   overflow   sticky: a write was dropped because the log was full
//   busy       FSM is outside IDLE
// ============================================================================
module z80_bus_responder #(
    parameter int AW          = 12,
    parameter int WAIT_CYCLES = 2,
    parameter int LOG_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] a,
    input  logic [7:0]  dout,
    output logic [7:0]  di,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        rfsh_n,
    output logic        wait_n,
    output logic        log_valid,
    output logic [24:0] log_data,
    input  logic        log_ready,
    output logic        overflow,
    output logic        busy
);

    localparam int PW = $clog2(LOG_DEPTH);
    localparam logic [PW:0] DEPTH_V = (PW+1)'(LOG_DEPTH);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 7) begin : g_wait_range_check
        $error("z80_bus_responder: WAIT_CYCLES must be in 0..7");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef Z80_RESP_WAIT_EN
        S_WAIT   = 2'd1,
`endif
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Cycle decode. Refresh (rfsh_n low) is never a memory access, and an
    // interrupt acknowledge (m1_n low with iorq_n low) is never an IO access.
    // ------------------------------------------------------------------
    logic mem_cycle, io_cycle, start;

    // NOTE: every signal written in always_comb gets a default first, so no
    //       path can leave it unassigned and infer a latch.
    always_comb begin
        mem_cycle = 1'b0;
        io_cycle  = 1'b0;
        if (!mreq_n && rfsh_n && (!rd_n || !wr_n)) mem_cycle = 1'b1;
        if (!iorq_n && m1_n && (!rd_n || !wr_n))   io_cycle  = 1'b1;
        start = mem_cycle || io_cycle;
    end

    // Latched access attributes
    logic [15:0] addr_q;
    logic        is_io_q;
    logic        is_write_q;

`ifdef Z80_RESP_WAIT_EN
    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);
    logic [2:0] wait_cnt_q;
    logic       strobes_held;

    // The latched strobe pair must stay asserted for the whole WAIT state.
    // Dropping it aborts the access.
    always_comb begin
        strobes_held = (is_io_q ? !iorq_n : !mreq_n) &&
                       (is_write_q ? !wr_n : !rd_n);
    end
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef Z80_RESP_WAIT_EN
                    if (WAIT_CYCLES > 0) state_d = S_WAIT;
                    else                 state_d = S_ACCESS;
`else
                    state_d = S_ACCESS;
`endif
                end
            end
`ifdef Z80_RESP_WAIT_EN
            S_WAIT: begin
                if (!strobes_held)           state_d = S_IDLE;
                else if (wait_cnt_q == 3'd1) state_d = S_ACCESS;
            end
`endif
            S_ACCESS: state_d = S_HOLD;
            S_HOLD: begin
                if (rd_n && wr_n) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    //       samples values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

`ifdef Z80_RESP_WAIT_EN
    assign wait_n = (state_q != S_WAIT);
`else
    assign wait_n = 1'b1;
`endif
    assign busy = (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Storage: RAM and IO register file
    // ------------------------------------------------------------------
    logic [7:0] ram     [2**AW];
    logic [7:0] io_regs [16];

    logic ram_we, io_we;
    assign ram_we = (state_q == S_ACCESS) && is_write_q && !is_io_q;
    assign io_we  = (state_q == S_ACCESS) && is_write_q &&  is_io_q;

    // NOTE: memory arrays have no reset. Their contents survive reset_n, and
    //       a reset-free array maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (ram_we) ram[addr_q[AW-1:0]] <= dout;
        if (io_we)  io_regs[addr_q[3:0]] <= dout;
    end

    // ------------------------------------------------------------------
    // Access latch, wait counter and read-data register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            is_io_q    <= 1'b0;
            is_write_q <= 1'b0;
            di         <= 8'hFF;
`ifdef Z80_RESP_WAIT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            if (state_q == S_IDLE && start) begin
                addr_q     <= a;
                is_io_q    <= !mem_cycle;
                is_write_q <= !wr_n;
`ifdef Z80_RESP_WAIT_EN
                wait_cnt_q <= WAIT_LOAD;
`endif
            end
`ifdef Z80_RESP_WAIT_EN
            if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q - 3'd1;
`endif
            // di is loaded at the end of ACCESS and held through HOLD. It
            // returns to 8'hFF on the edge that leaves HOLD.
            if (state_q == S_ACCESS && !is_write_q)
                di <= is_io_q ? io_regs[addr_q[3:0]] : ram[addr_q[AW-1:0]];
            else if (state_q == S_HOLD && rd_n && wr_n)
                di <= 8'hFF;
        end
    end

    // ------------------------------------------------------------------
    // Write-log FIFO. A push into a full log succeeds only if a pop happens
    // on the same edge. Otherwise the entry is dropped and overflow sticks.
    // ------------------------------------------------------------------
    logic [24:0]   log_mem [LOG_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          log_empty, log_full, push, pop, push_ok;

    assign log_empty = (count_q == '0);
    assign log_full  = (count_q == DEPTH_V);
    assign push      = (state_q == S_ACCESS) && is_write_q;
    assign pop       = !log_empty && log_ready;
    assign push_ok   = push && (!log_full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) log_mem[wr_ptr_q] <= {is_io_q, addr_q, dout};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push && log_full && !pop) overflow <= 1'b1;
        end
    end

    assign log_valid = !log_empty;
    assign log_data  = log_empty ? '0 : log_mem[rd_ptr_q];

endmodule
